execute_cc_stage: RTL and testbench

- Execute-stage back half of the Y86-64 pipeline. Sits directly downstream of the 64-bit add/sub ALU.
- Consumes the ALU result and overflow flag and owns the condition-code register (ZF/SF/OF).
- Evaluates Cnd for jXX/cmovXX and registers the E->M pipeline register that feeds the memory stage.

---
 rtl/y86_pkg.sv | 30 +++
 rtl/cond_eval.sv | 31 +++
 rtl/execute_cc_stage.sv | 115 +++++++++++
 tb/tb_execute_cc_stage.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: icodes, jXX/cmovXX condition codes, status codes, CC bit positions.
package y86_pkg;

  localparam logic [3:0] I_NOP  = 4'h1;
  localparam logic [3:0] I_CMOV = 4'h2;
  localparam logic [3:0] I_OPQ  = 4'h6;
  localparam logic [3:0] I_JXX  = 4'h7;

  localparam logic [3:0] C_ALWAYS = 4'h0;
  localparam logic [3:0] C_LE     = 4'h1;
  localparam logic [3:0] C_L      = 4'h2;
  localparam logic [3:0] C_E      = 4'h3;
  localparam logic [3:0] C_NE     = 4'h4;
  localparam logic [3:0] C_GE     = 4'h5;
  localparam logic [3:0] C_G      = 4'h6;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  localparam logic [2:0] CC_RESET = 3'b100;

endpackage

// File: rtl/cond_eval.sv
// Condition evaluator: {ZF,SF,OF} and ifun -> Cnd, purely combinational.
// Shared by the execute stage and the fetch-side predictor checks.
module cond_eval
  import y86_pkg::*;
(
  input  logic [2:0] cc,
  input  logic [3:0] ifun,
  output logic       cnd
);

  logic zf, sf, of;

  assign zf = cc[CC_ZF];
  assign sf = cc[CC_SF];
  assign of = cc[CC_OF];

  always_comb begin
    cnd = 1'b0;
    case (ifun)
      C_ALWAYS: cnd = 1'b1;
      C_LE:     cnd = (sf ^ of) | zf;
      C_L:      cnd = sf ^ of;
      C_E:      cnd = zf;
      C_NE:     cnd = ~zf;
      C_GE:     cnd = ~(sf ^ of);
      C_G:      cnd = ~(sf ^ of) & ~zf;
      default:  cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/execute_cc_stage.sv
// Execute back half: owns CC, evaluates Cnd, registers E->M (1 cycle); m_stall holds, m_bubble clears.
// Optional COND_STATS_EN adds wrapping jXX executed/taken counters.
module execute_cc_stage
  import y86_pkg::*;
#(
  parameter int W      = 64,
  parameter int STAT_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              e_valid,
  input  logic [3:0]        e_icode,
  input  logic [3:0]        e_ifun,
  input  logic [STAT_W-1:0] e_stat,
  input  logic [W-1:0]      e_valA,
  input  logic [3:0]        e_dstE,
  input  logic [3:0]        e_dstM,
  input  logic [W-1:0]      alu_res,
  input  logic              alu_of,
  input  logic              m_stat_exc,
  input  logic              w_stat_exc,
  input  logic              m_stall,
  input  logic              m_bubble,
  output logic [2:0]        cc_out,
  output logic              e_cnd,
  output logic              M_valid,
  output logic [3:0]        M_icode,
  output logic [STAT_W-1:0] M_stat,
  output logic              M_cnd,
  output logic [W-1:0]      M_valE,
  output logic [W-1:0]      M_valA,
  output logic [3:0]        M_dstE,
  output logic [3:0]        M_dstM
`ifdef COND_STATS_EN
  ,
  output logic [31:0]       stat_cond_cnt,
  output logic [31:0]       stat_taken_cnt
`endif
);

  logic       cnd_raw;
  logic       cc_upd;
  logic       m_clear;
  logic       m_load;
  logic [3:0] dste_nxt;

  cond_eval u_cond_eval (
    .cc   (cc_out),
    .ifun (e_ifun),
    .cnd  (cnd_raw)
  );

  assign e_cnd = e_valid & cnd_raw;

  // An OPq shadowed by a faulting older instruction must not disturb CC; bubble does not block.
  assign cc_upd = e_valid && (e_icode == I_OPQ) && !m_stat_exc && !w_stat_exc && !m_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      cc_out <= CC_RESET;
    end else if (cc_upd) begin
      cc_out[CC_ZF] <= (alu_res == '0);
      cc_out[CC_SF] <= alu_res[W-1];
      cc_out[CC_OF] <= alu_of;
    end
  end

  // Not-taken cmov becomes a no-write by steering its destination to RNONE.
  assign dste_nxt = ((e_icode == I_CMOV) && !e_cnd) ? RNONE : e_dstE;

  // Invalid E contents load the same NOP image as a bubble.
  assign m_clear = rst || (!m_stall && (m_bubble || !e_valid));
  assign m_load  = !rst && !m_stall && !m_bubble && e_valid;

  always_ff @(posedge clk) begin
    if (m_clear) begin
      M_valid <= 1'b0;
      M_icode <= I_NOP;
      M_stat  <= STAT_W'(STAT_AOK);
      M_cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= RNONE;
      M_dstM  <= RNONE;
    end else if (m_load) begin
      M_valid <= 1'b1;
      M_icode <= e_icode;
      M_stat  <= e_stat;
      M_cnd   <= e_cnd;
      M_valE  <= alu_res;
      M_valA  <= e_valA;
      M_dstE  <= dste_nxt;
      M_dstM  <= e_dstM;
    end
  end

`ifdef COND_STATS_EN
  logic jxx_load;

  assign jxx_load = m_load && (e_icode == I_JXX);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_cond_cnt  <= '0;
      stat_taken_cnt <= '0;
    end else if (jxx_load) begin
      stat_cond_cnt <= stat_cond_cnt + 32'd1;
      if (e_cnd) begin
        stat_taken_cnt <= stat_taken_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_execute_cc_stage.sv
// Directed table-driven bench for execute_cc_stage plus hand sequences for stall/bubble/reset/stats.
module tb_execute_cc_stage;

  localparam int W      = 64;
  localparam int STAT_W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              e_valid;
  logic [3:0]        e_icode;
  logic [3:0]        e_ifun;
  logic [STAT_W-1:0] e_stat;
  logic [W-1:0]      e_valA;
  logic [3:0]        e_dstE;
  logic [3:0]        e_dstM;
  logic [W-1:0]      alu_res;
  logic              alu_of;
  logic              m_stat_exc;
  logic              w_stat_exc;
  logic              m_stall;
  logic              m_bubble;
  logic [2:0]        cc_out;
  logic              e_cnd;
  logic              M_valid;
  logic [3:0]        M_icode;
  logic [STAT_W-1:0] M_stat;
  logic              M_cnd;
  logic [W-1:0]      M_valE;
  logic [W-1:0]      M_valA;
  logic [3:0]        M_dstE;
  logic [3:0]        M_dstM;
`ifdef COND_STATS_EN
  logic [31:0]       stat_cond_cnt;
  logic [31:0]       stat_taken_cnt;
`endif

  execute_cc_stage #(.W(W), .STAT_W(STAT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .e_valid    (e_valid),
    .e_icode    (e_icode),
    .e_ifun     (e_ifun),
    .e_stat     (e_stat),
    .e_valA     (e_valA),
    .e_dstE     (e_dstE),
    .e_dstM     (e_dstM),
    .alu_res    (alu_res),
    .alu_of     (alu_of),
    .m_stat_exc (m_stat_exc),
    .w_stat_exc (w_stat_exc),
    .m_stall    (m_stall),
    .m_bubble   (m_bubble),
    .cc_out     (cc_out),
    .e_cnd      (e_cnd),
    .M_valid    (M_valid),
    .M_icode    (M_icode),
    .M_stat     (M_stat),
    .M_cnd      (M_cnd),
    .M_valE     (M_valE),
    .M_valA     (M_valA),
    .M_dstE     (M_dstE),
    .M_dstM     (M_dstM)
`ifdef COND_STATS_EN
    ,
    .stat_cond_cnt  (stat_cond_cnt),
    .stat_taken_cnt (stat_taken_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        v;
    logic [3:0]  ic;
    logic [3:0]  f;
    logic [63:0] res;
    logic        of;
    logic [3:0]  dste;
    logic        mx;
    logic        wx;
    logic        exp_cnd;
    logic [2:0]  exp_cc;
  } vec_t;

  vec_t tbl[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  function automatic vec_t mk(logic v, logic [3:0] ic, logic [3:0] f, logic [63:0] res,
                              logic of, logic [3:0] dste, logic mx, logic wx,
                              logic exp_cnd, logic [2:0] exp_cc);
    vec_t r;
    r.v = v; r.ic = ic; r.f = f; r.res = res; r.of = of; r.dste = dste;
    r.mx = mx; r.wx = wx; r.exp_cnd = exp_cnd; r.exp_cc = exp_cc;
    return r;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] f,
                       input logic [63:0] res, input logic of, input logic [3:0] dste);
    e_valid = v; e_icode = ic; e_ifun = f; alu_res = res; alu_of = of; e_dstE = dste;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] NEG_MIN = 64'h8000_0000_0000_0000;

  initial begin
    logic [3:0] exp_dste;
    rst = 1'b1; m_stall = 1'b1; m_bubble = 1'b1; m_stat_exc = 1'b0; w_stat_exc = 1'b0;
    e_stat = 3'd1; e_valA = 64'h0; e_dstM = 4'h5;
    drive(1'b1, 4'h6, 4'h0, 64'h5, 1'b0, 4'h2);
    step(); step();

    // Reset wins over stall and bubble, and over a live OPq.
    check("rst_cc", cc_out, 3'b100);
    check("rst_M_valid", M_valid, 1'b0);
    check("rst_M_icode", M_icode, 4'h1);
    check("rst_M_stat", M_stat, 3'd1);
    check("rst_M_cnd", M_cnd, 1'b0);
    check("rst_M_valE", M_valE, 64'h0);
    check("rst_M_dstE", M_dstE, 4'hF);
    check("rst_M_dstM", M_dstM, 4'hF);

    rst = 1'b0; m_stall = 1'b0; m_bubble = 1'b0;
    drive(1'b0, 4'h1, 4'h0, 64'h0, 1'b0, 4'hF);
    step();
    check("idle_cc", cc_out, 3'b100);
    check("idle_M_icode", M_icode, 4'h1);
    check("idle_M_dstE", M_dstE, 4'hF);
    check("idle_M_valid", M_valid, 1'b0);

    //          v     ic    f     res      of    dstE  mx    wx    cnd   cc-after
    tbl.push_back(mk(1'b1, 4'h6, 4'h0, 64'h0,   1'b0, 4'h2, 1'b0, 1'b0, 1'b1, 3'b100));
    tbl.push_back(mk(1'b1, 4'h6, 4'h0, NEG_MIN, 1'b1, 4'h2, 1'b0, 1'b0, 1'b1, 3'b011));
    tbl.push_back(mk(1'b1, 4'h7, 4'h1, 64'h10,  1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 3'b011));
    tbl.push_back(mk(1'b1, 4'h7, 4'h2, 64'h11,  1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 3'b011));
    tbl.push_back(mk(1'b1, 4'h7, 4'h5, 64'h12,  1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 3'b011));
    tbl.push_back(mk(1'b1, 4'h7, 4'h6, 64'h13,  1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 3'b011));
    tbl.push_back(mk(1'b1, 4'h7, 4'h3, 64'h14,  1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 3'b011));
    tbl.push_back(mk(1'b1, 4'h7, 4'h4, 64'h15,  1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 3'b011));
    tbl.push_back(mk(1'b1, 4'h7, 4'h9, 64'h16,  1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 3'b011));
    tbl.push_back(mk(1'b0, 4'h7, 4'h0, 64'h17,  1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 3'b011));
    tbl.push_back(mk(1'b0, 4'h6, 4'h0, 64'h0,   1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 3'b011));
    tbl.push_back(mk(1'b1, 4'h6, 4'h0, 64'h0,   1'b0, 4'h2, 1'b0, 1'b0, 1'b1, 3'b100));
    tbl.push_back(mk(1'b1, 4'h2, 4'h4, 64'h20,  1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 3'b100));
    tbl.push_back(mk(1'b1, 4'h2, 4'h3, 64'h21,  1'b0, 4'h3, 1'b0, 1'b0, 1'b1, 3'b100));
    tbl.push_back(mk(1'b1, 4'h6, 4'h0, 64'h5,   1'b0, 4'h2, 1'b1, 1'b0, 1'b1, 3'b100));
    tbl.push_back(mk(1'b1, 4'h6, 4'h0, 64'h5,   1'b0, 4'h2, 1'b0, 1'b1, 1'b1, 3'b100));
    tbl.push_back(mk(1'b1, 4'h6, 4'h0, 64'h5,   1'b0, 4'h2, 1'b0, 1'b0, 1'b1, 3'b000));
    tbl.push_back(mk(1'b1, 4'h2, 4'h4, 64'h22,  1'b0, 4'h3, 1'b0, 1'b0, 1'b1, 3'b000));
    tbl.push_back(mk(1'b1, 4'h2, 4'h1, 64'h23,  1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 3'b000));
    tbl.push_back(mk(1'b1, 4'h6, 4'h0, 64'h7,   1'b1, 4'h2, 1'b0, 1'b0, 1'b1, 3'b001));
    tbl.push_back(mk(1'b1, 4'h7, 4'h1, 64'h30,  1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 3'b001));
    tbl.push_back(mk(1'b1, 4'h7, 4'h2, 64'h31,  1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 3'b001));
    tbl.push_back(mk(1'b1, 4'h7, 4'h5, 64'h32,  1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 3'b001));
    tbl.push_back(mk(1'b1, 4'h7, 4'h6, 64'h33,  1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 3'b001));
    tbl.push_back(mk(1'b1, 4'h7, 4'h3, 64'h34,  1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 3'b001));
    tbl.push_back(mk(1'b1, 4'h2, 4'h2, 64'h35,  1'b0, 4'h3, 1'b0, 1'b0, 1'b1, 3'b001));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].ic, tbl[i].f, tbl[i].res, tbl[i].of, tbl[i].dste);
      m_stat_exc = tbl[i].mx;
      w_stat_exc = tbl[i].wx;
      e_valA = 64'(i) * 64'h111;
      #1;
      check($sformatf("v%0d_e_cnd", i), e_cnd, tbl[i].exp_cnd);
      step();
      check($sformatf("v%0d_cc", i), cc_out, tbl[i].exp_cc);
      check($sformatf("v%0d_M_valid", i), M_valid, tbl[i].v);
      check($sformatf("v%0d_M_icode", i), M_icode, tbl[i].v ? tbl[i].ic : 4'h1);
      check($sformatf("v%0d_M_cnd", i), M_cnd, tbl[i].exp_cnd);
      if (!tbl[i].v) exp_dste = 4'hF;
      else if (tbl[i].ic == 4'h2 && !tbl[i].exp_cnd) exp_dste = 4'hF;
      else exp_dste = tbl[i].dste;
      check($sformatf("v%0d_M_dstE", i), M_dstE, exp_dste);
      if (tbl[i].v) begin
        check($sformatf("v%0d_M_valE", i), M_valE, tbl[i].res);
        check($sformatf("v%0d_M_valA", i), M_valA, 64'(i) * 64'h111);
        check($sformatf("v%0d_M_dstM", i), M_dstM, 4'h5);
        check($sformatf("v%0d_M_stat", i), M_stat, 3'd1);
      end
    end
    m_stat_exc = 1'b0; w_stat_exc = 1'b0;

    // Stall: load a known OPq, then hold it two cycles while E changes.
    drive(1'b1, 4'h6, 4'h0, 64'h1234, 1'b0, 4'h4);
    step();
    check("pre_stall_valE", M_valE, 64'h1234);
    check("pre_stall_cc", cc_out, 3'b000);
    m_stall = 1'b1;
    drive(1'b1, 4'h6, 4'h0, 64'h0, 1'b1, 4'h9);
    for (int k = 0; k < 2; k++) begin
      step();
      check($sformatf("stall%0d_M_icode", k), M_icode, 4'h6);
      check($sformatf("stall%0d_M_valE", k), M_valE, 64'h1234);
      check($sformatf("stall%0d_M_dstE", k), M_dstE, 4'h4);
      check($sformatf("stall%0d_cc", k), cc_out, 3'b000);
    end

    // Bubble clears E->M but does not suppress the CC update.
    m_stall = 1'b0; m_bubble = 1'b1;
    drive(1'b1, 4'h6, 4'h0, NEG_MIN, 1'b0, 4'h4);
    step();
    check("bubble_M_icode", M_icode, 4'h1);
    check("bubble_M_valid", M_valid, 1'b0);
    check("bubble_M_dstE", M_dstE, 4'hF);
    check("bubble_cc", cc_out, 3'b010);

    // Reset mid-run with stall asserted.
    m_bubble = 1'b0; m_stall = 1'b1; rst = 1'b1;
    drive(1'b1, 4'h6, 4'h0, 64'h9, 1'b1, 4'h4);
    step();
    check("rst2_cc", cc_out, 3'b100);
    check("rst2_M_icode", M_icode, 4'h1);
    check("rst2_M_valid", M_valid, 1'b0);
    rst = 1'b0; m_stall = 1'b0;

`ifdef COND_STATS_EN
    check("stat_rst_cond", stat_cond_cnt, 32'd0);
    check("stat_rst_taken", stat_taken_cnt, 32'd0);
    drive(1'b1, 4'h7, 4'h0, 64'h0, 1'b0, 4'hF);
    step();
    m_stall = 1'b1;
    step();
    m_stall = 1'b0; m_bubble = 1'b1;
    step();
    m_bubble = 1'b0;
    drive(1'b1, 4'h7, 4'h4, 64'h0, 1'b0, 4'hF);
    step();
    drive(1'b1, 4'h7, 4'h3, 64'h0, 1'b0, 4'hF);
    step();
    check("stat_cond_3", stat_cond_cnt, 32'd3);
    check("stat_taken_2", stat_taken_cnt, 32'd2);
    drive(1'b0, 4'h1, 4'h0, 64'h0, 1'b0, 4'hF);
    step();
    dut.stat_cond_cnt = 32'hFFFF_FFFF;
    drive(1'b1, 4'h7, 4'h0, 64'h0, 1'b0, 4'hF);
    step();
    check("stat_cond_wrap", stat_cond_cnt, 32'd0);
    check("stat_taken_3", stat_taken_cnt, 32'd3);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
